// File: rtl/pht_upd_ctrl.sv
// pht_upd_ctrl: dual-slot branch-update FIFO that drains into a 2-bit
// counter PHT by read-modify-write, plus a full-table clear sweep.
module pht_upd_ctrl #(
    parameter int         IDX_W    = 11,
    parameter int         DEPTH    = 4,
    parameter logic [1:0] CLR_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_upd0_vld,
    input  logic [IDX_W-1:0] i_upd0_idx,
    input  logic             i_upd0_taken,
    input  logic             i_upd1_vld,
    input  logic [IDX_W-1:0] i_upd1_idx,
    input  logic             i_upd1_taken,
    output logic             o_upd_rdy,
    input  logic             i_clr_req,
    output logic             o_clr_busy,
    output logic [IDX_W-1:0] o_pht_ridx,
    input  logic [1:0]       i_pht_rd_entry,
    output logic             o_pht_wren,
    output logic [IDX_W-1:0] o_pht_widx,
    output logic [1:0]       o_pht_wr_entry
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_t;

    state_e           state_q, state_d;
    upd_t             fifo_q [DEPTH];
    upd_t             fifo_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

    logic             rdy, acc0, acc1, deq;
    logic [1:0]       n_acc;
    logic [1:0]       sat;
    upd_t             head, slot0, slot1;

    // Ready comes only from registered state so upstream sees no comb loop.
    assign rdy   = (state_q == RUN) &&
                   ((CNT_W'(DEPTH) - cnt_q) >= CNT_W'(2));
    assign acc0  = i_upd0_vld & rdy;
    assign acc1  = i_upd1_vld & rdy;
    assign n_acc = {1'b0, acc0} + {1'b0, acc1};
    assign deq   = (state_q != CLEAR) && (cnt_q != '0);
    assign head  = fifo_q[rd_ptr_q];
    assign slot0 = '{idx: i_upd0_idx, taken: i_upd0_taken};
    assign slot1 = '{idx: i_upd1_idx, taken: i_upd1_taken};

    assign o_upd_rdy  = rdy;
    assign o_clr_busy = (state_q != RUN);

    always_comb begin
        if (head.taken) begin
            sat = (i_pht_rd_entry == 2'b11) ? 2'b11 : i_pht_rd_entry + 2'd1;
        end else begin
            sat = (i_pht_rd_entry == 2'b00) ? 2'b00 : i_pht_rd_entry - 2'd1;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        if (acc0) begin
            fifo_d[wr_ptr_d] = slot0;
            wr_ptr_d         = wr_ptr_d + PTR_W'(1);
        end
        if (acc1) begin
            fifo_d[wr_ptr_d] = slot1;
            wr_ptr_d         = wr_ptr_d + PTR_W'(1);
        end
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(n_acc) - CNT_W'(deq);
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            RUN: begin
                if (i_clr_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = CLEAR;
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == '1) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        o_pht_wren     = 1'b0;
        o_pht_ridx     = '0;
        o_pht_widx     = '0;
        o_pht_wr_entry = '0;
        unique case (1'b1)
            deq: begin
                o_pht_wren     = 1'b1;
                o_pht_ridx     = head.idx;
                o_pht_widx     = head.idx;
                o_pht_wr_entry = sat;
            end
            (state_q == CLEAR): begin
                o_pht_wren     = 1'b1;
                o_pht_widx     = clr_cnt_q;
                o_pht_wr_entry = CLR_INIT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            clr_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            clr_cnt_q <= clr_cnt_d;
            fifo_q    <= fifo_d;
        end
    end

endmodule

// File: tb/tb_pht_upd_ctrl.sv
// tb_pht_upd_ctrl: directed and random checks of the PHT update
// scheduler against a behavioural PHT and a reference counter model.
module tb_pht_upd_ctrl;
    localparam int IDX_W = 11;
    localparam int NENT  = 1 << IDX_W;
    localparam int NRND  = 10000;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_upd0_vld, i_upd0_taken;
    logic [IDX_W-1:0] i_upd0_idx;
    logic             i_upd1_vld, i_upd1_taken;
    logic [IDX_W-1:0] i_upd1_idx;
    logic             o_upd_rdy;
    logic             i_clr_req;
    logic             o_clr_busy;
    logic [IDX_W-1:0] o_pht_ridx;
    logic [1:0]       i_pht_rd_entry;
    logic             o_pht_wren;
    logic [IDX_W-1:0] o_pht_widx;
    logic [1:0]       o_pht_wr_entry;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [1:0]       v;
    } wr_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             t;
    } ru_t;

    logic [1:0] pht  [NENT];
    logic [1:0] rpht [NENT];
    wr_t        wlog [$];
    ru_t        rq   [$];
    int         n_chk = 0;
    int         n_fail = 0;

    pht_upd_ctrl #(.IDX_W(IDX_W), .DEPTH(4), .CLR_INIT(2'b01)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_upd0_vld     (i_upd0_vld),
        .i_upd0_idx     (i_upd0_idx),
        .i_upd0_taken   (i_upd0_taken),
        .i_upd1_vld     (i_upd1_vld),
        .i_upd1_idx     (i_upd1_idx),
        .i_upd1_taken   (i_upd1_taken),
        .o_upd_rdy      (o_upd_rdy),
        .i_clr_req      (i_clr_req),
        .o_clr_busy     (o_clr_busy),
        .o_pht_ridx     (o_pht_ridx),
        .i_pht_rd_entry (i_pht_rd_entry),
        .o_pht_wren     (o_pht_wren),
        .o_pht_widx     (o_pht_widx),
        .o_pht_wr_entry (o_pht_wr_entry)
    );

    always #5 clk = ~clk;

    assign i_pht_rd_entry = pht[o_pht_ridx];

    always @(posedge clk) begin
        if (o_pht_wren) pht[o_pht_widx] <= o_pht_wr_entry;
    end

    always @(negedge clk) begin
        if (o_pht_wren) wlog.push_back('{idx: o_pht_widx, v: o_pht_wr_entry});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] v, input logic t);
        if (t) return (v == 2'd3) ? 2'd3 : v + 2'd1;
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_upd0_vld = 0; i_upd1_vld = 0; i_clr_req = 0;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_rdy"},  o_upd_rdy, 1);
        chk({tag, "_busy"}, o_clr_busy, 0);
        chk({tag, "_wren"}, o_pht_wren, 0);
        chk({tag, "_ridx"}, o_pht_ridx, 0);
        chk({tag, "_widx"}, o_pht_widx, 0);
        chk({tag, "_wr"},   o_pht_wr_entry, 0);
    endtask

    task automatic rnd_mon();
        ru_t        e;
        logic [1:0] x;
        if (!o_pht_wren) return;
        if (rq.size() == 0) begin
            chk("rnd_spurious_wr", 1, 0);
            return;
        end
        e = rq.pop_front();
        x = sat(rpht[e.idx], e.t);
        chk("rnd_widx", o_pht_widx, e.idx);
        chk("rnd_ridx", o_pht_ridx, e.idx);
        chk("rnd_wr", o_pht_wr_entry, x);
        rpht[e.idx] = x;
    endtask

    initial begin
        int cnt, pairs, bad;
        logic saw_low, exp_rdy, found, r;
        int sent;

        rst = 1;
        idle_in();
        i_upd0_idx = 0; i_upd0_taken = 0;
        i_upd1_idx = 0; i_upd1_taken = 0;
        for (int i = 0; i < NENT; i++) pht[i] = 2'd0;
        @(negedge clk);
        chk_idle_outs("reset");
        step();
        rst = 0;

        // single update
        wlog.delete();
        i_upd0_vld = 1; i_upd0_idx = 5; i_upd0_taken = 1;
        step();
        i_upd0_vld = 0;
        @(negedge clk);
        chk("single_wren", o_pht_wren, 1);
        chk("single_ridx", o_pht_ridx, 5);
        chk("single_widx", o_pht_widx, 5);
        chk("single_wr", o_pht_wr_entry, 2'b01);
        @(negedge clk);
        chk("single_after_wren", o_pht_wren, 0);
        chk("single_after_widx", o_pht_widx, 0);

        // saturation up then down on one index
        for (int d = 0; d < 2; d++) begin
            step();
            wlog.delete();
            i_upd0_vld = 1; i_upd0_idx = 7; i_upd0_taken = (d == 0);
            i_upd1_vld = 1; i_upd1_idx = 7; i_upd1_taken = (d == 0);
            step();
            step();
            idle_in();
            repeat (6) step();
            chk("sat_nwr", wlog.size(), 4);
            for (int k = 0; k < 4; k++) begin
                chk("sat_idx", wlog[k].idx, 7);
                if (d == 0) chk("sat_up", wlog[k].v, (k < 2) ? k + 1 : 3);
                else chk("sat_dn", wlog[k].v, (k < 2) ? 2 - k : 0);
            end
        end

        // ordering and backpressure with held valids
        wlog.delete();
        cnt = 0; pairs = 0; saw_low = 0;
        i_upd0_vld = 1; i_upd0_idx = 10; i_upd0_taken = 1;
        i_upd1_vld = 1; i_upd1_idx = 20; i_upd1_taken = 0;
        for (int c = 0; c < 30 && pairs < 3; c++) begin
            @(negedge clk);
            exp_rdy = (4 - cnt) >= 2;
            chk("bp_rdy", o_upd_rdy, exp_rdy);
            if (!exp_rdy) saw_low = 1;
            cnt = cnt + (exp_rdy ? 2 : 0) - ((cnt != 0) ? 1 : 0);
            if (exp_rdy) pairs++;
            step();
        end
        idle_in();
        repeat (6) step();
        chk("bp_pairs", pairs, 3);
        chk("bp_rdy_dropped", saw_low, 1);
        chk("bp_nwr", wlog.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk("bp_order", wlog[k].idx, (k % 2 == 0) ? 10 : 20);
            chk("bp_val", wlog[k].v, (k % 2 == 0) ? k / 2 + 1 : 0);
        end
        chk("bp_pht10", pht[10], 3);
        chk("bp_pht20", pht[20], 0);

        // clear with two updates queued in the request cycle
        i_upd0_vld = 1; i_upd0_idx = 30; i_upd0_taken = 1;
        i_upd1_vld = 1; i_upd1_idx = 31; i_upd1_taken = 1;
        i_clr_req = 1;
        step();
        idle_in();
        @(negedge clk);
        chk("clr_busy", o_clr_busy, 1);
        chk("clr_rdy", o_upd_rdy, 0);
        chk("clr_d0_wren", o_pht_wren, 1);
        chk("clr_d0_widx", o_pht_widx, 30);
        chk("clr_d0_wr", o_pht_wr_entry, 1);
        @(negedge clk);
        chk("clr_d1_widx", o_pht_widx, 31);
        chk("clr_d1_wr", o_pht_wr_entry, 1);
        @(negedge clk);
        chk("clr_gap_wren", o_pht_wren, 0);
        chk("clr_gap_busy", o_clr_busy, 1);
        bad = 0;
        for (int i = 0; i < NENT; i++) begin
            @(negedge clk);
            if (o_pht_wren !== 1'b1 || o_pht_widx !== IDX_W'(i) ||
                o_pht_wr_entry !== 2'b01 || o_clr_busy !== 1'b1 ||
                o_upd_rdy !== 1'b0) bad++;
        end
        chk("clr_sweep_bad", bad, 0);
        @(negedge clk);
        chk("clr_done_busy", o_clr_busy, 0);
        chk("clr_done_rdy", o_upd_rdy, 1);
        chk("clr_done_wren", o_pht_wren, 0);
        chk("clr_pht10", pht[10], 1);

        // reset in the middle of a clear sweep
        step();
        i_clr_req = 1;
        step();
        i_clr_req = 0;
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (o_pht_wren && o_pht_widx == 100) found = 1;
        end
        chk("mid_found_100", found, 1);
        #1 rst = 1;
        #1 chk_idle_outs("mid_rst");
        step();
        rst = 0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_pht_wren !== 1'b0) bad++;
        end
        chk("mid_no_wren", bad, 0);
        step();
        i_upd0_vld = 1; i_upd0_idx = 3; i_upd0_taken = 1;
        step();
        i_upd0_vld = 0;
        @(negedge clk);
        chk("mid_post_wren", o_pht_wren, 1);
        chk("mid_post_widx", o_pht_widx, 3);
        chk("mid_post_wr", o_pht_wr_entry, 2);

        // random dual-slot traffic with stalls
        rst = 1;
        step();
        for (int i = 0; i < NENT; i++) begin
            pht[i] = 2'd0;
            rpht[i] = 2'd0;
        end
        rst = 0;
        rq.delete();
        idle_in();
        sent = 0;
        for (int c = 0; c < 40000 && (sent < NRND || i_upd0_vld || i_upd1_vld);
             c++) begin
            @(negedge clk);
            rnd_mon();
            r = o_upd_rdy;
            if (r && i_upd0_vld) rq.push_back('{idx: i_upd0_idx, t: i_upd0_taken});
            if (r && i_upd1_vld) rq.push_back('{idx: i_upd1_idx, t: i_upd1_taken});
            step();
            if (r || !(i_upd0_vld || i_upd1_vld)) begin
                if (sent < NRND && $urandom_range(0, 3) != 0) begin
                    i_upd0_vld   = 1'($urandom_range(0, 1));
                    i_upd1_vld   = 1'($urandom_range(0, 1));
                    i_upd0_idx   = IDX_W'($urandom_range(0, 15));
                    i_upd1_idx   = IDX_W'($urandom_range(0, 15));
                    i_upd0_taken = 1'($urandom_range(0, 1));
                    i_upd1_taken = 1'($urandom_range(0, 1));
                    sent += int'(i_upd0_vld) + int'(i_upd1_vld);
                end else begin
                    i_upd0_vld = 0;
                    i_upd1_vld = 0;
                end
            end
        end
        idle_in();
        repeat (10) begin
            @(negedge clk);
            rnd_mon();
        end
        chk("rnd_all_sent", sent >= NRND, 1);
        chk("rnd_q_empty", rq.size(), 0);
        bad = 0;
        for (int i = 0; i < NENT; i++) if (pht[i] !== rpht[i]) bad++;
        chk("rnd_final_pht", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
